// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Shares one byte-wide RAM port between instruction fetch and
//            load/store. Arbitrates (MEM first), sequences 1/2/4-byte
//            little-endian accesses one byte per cycle, and raises per-stage
//            stall requests until each access completes.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_data,
    output logic              if_done,
    output logic              if_stall_req,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              mem_stall_req,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              r_owner_mem;     // 1 = MEM owns the access, 0 = IF
    logic              r_we;
    logic [RAM_AW-1:0] r_addr;
    logic [2:0]        r_len;           // bytes in this access: 1, 2 or 4
    logic [1:0]        r_k;             // index of the byte currently on the RAM port
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;           // read bytes gathered so far

    logic              w_grant_mem;
    logic              w_grant_if;
    logic              w_last;
    logic              w_abort;
    logic [2:0]        w_mem_len;
    logic [1:0]        w_k_next;
    logic [RAM_AW-1:0] w_addr_next;
    logic [31:0]       w_result;
    logic              w_unused;

    // Upper address bits fall outside the RAM and are intentionally ignored.
    assign w_unused = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: IDLE grants, BUSY runs N byte cycles (IF can be aborted), DONE is one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_mem || w_grant_if) begin
                    w_state_next = c_BUSY;
                end
            end
            c_BUSY: begin
                if (w_abort) begin
                    w_state_next = c_IDLE;
                end else if (w_last) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Output/decode: arbitration, byte sequencing helpers and combinational stall requests.
    always_comb begin
        w_grant_mem   = mem_req;
        w_grant_if    = if_req & ~if_flush & ~mem_req;
        w_abort       = ~r_owner_mem & if_flush;
        w_last        = (({1'b0, r_k} + 3'd1) == r_len);
        w_k_next      = r_k + 2'd1;
        w_addr_next   = r_addr + {{(RAM_AW-2){1'b0}}, w_k_next};
        case (mem_size)
            2'b00:   w_mem_len = 3'd1;
            2'b01:   w_mem_len = 3'd2;
            default: w_mem_len = 3'd4;
        endcase
        // The byte on ram_din belongs to the address driven during this cycle.
        w_result                     = r_buf;
        w_result[{r_k, 3'b000} +: 8] = ram_din;
        if_stall_req  = if_req & ~if_done;
        mem_stall_req = mem_req & ~mem_done;
    end

    // Datapath: latch the request on grant, step the RAM port each cycle, publish results on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner_mem <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_len       <= 3'd0;
            r_k         <= 2'd0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            ram_addr    <= '0;
            ram_dout    <= 8'd0;
            ram_wr      <= 1'b0;
            if_data     <= 32'd0;
            mem_rdata   <= 32'd0;
            if_done     <= 1'b0;
            mem_done    <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_mem) begin
                        r_owner_mem <= 1'b1;
                        r_we        <= mem_we;
                        r_addr      <= mem_addr[RAM_AW-1:0];
                        r_len       <= w_mem_len;
                        r_k         <= 2'd0;
                        r_wdata     <= mem_wdata;
                        r_buf       <= 32'd0;
                        ram_addr    <= mem_addr[RAM_AW-1:0];
                        ram_dout    <= mem_wdata[7:0];
                        ram_wr      <= mem_we;
                    end else if (w_grant_if) begin
                        r_owner_mem <= 1'b0;
                        r_we        <= 1'b0;
                        r_addr      <= if_addr[RAM_AW-1:0];
                        r_len       <= 3'd4;
                        r_k         <= 2'd0;
                        r_wdata     <= 32'd0;
                        r_buf       <= 32'd0;
                        ram_addr    <= if_addr[RAM_AW-1:0];
                        ram_dout    <= 8'd0;
                        ram_wr      <= 1'b0;
                    end
                end
                c_BUSY: begin
                    if (w_abort) begin
                        ram_wr <= 1'b0;
                    end else if (w_last) begin
                        ram_wr <= 1'b0;
                        if (r_owner_mem) begin
                            mem_done <= 1'b1;
                            if (!r_we) begin
                                mem_rdata <= w_result;
                            end
                        end else begin
                            if_done <= 1'b1;
                            if_data <= w_result;
                        end
                    end else begin
                        r_buf    <= w_result;
                        r_k      <= w_k_next;
                        ram_addr <= w_addr_next;
                        ram_dout <= r_wdata[{w_k_next, 3'b000} +: 8];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Self-checking bench for mem_ctrl with a byte-array RAM and a
//            shadow-memory reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    localparam int RAM_AW = 17;
    localparam int RAM_SZ = 1 << RAM_AW;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_flush;
    logic [31:0]       if_data;
    logic              if_done;
    logic              if_stall_req;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              mem_stall_req;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic [7:0]        ram_din;

    logic [7:0]        ram    [RAM_SZ];
    logic [7:0]        shadow [RAM_SZ];
    logic              bd_we;
    logic [RAM_AW-1:0] bd_addr;
    logic [7:0]        bd_data;

    int          checks;
    int          failures;
    logic [31:0] exp_if_data;
    logic [31:0] exp_mem_rdata;

    mem_ctrl #(.RAM_AW(RAM_AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_flush     (if_flush),
        .if_data      (if_data),
        .if_done      (if_done),
        .if_stall_req (if_stall_req),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .mem_stall_req(mem_stall_req),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .ram_wr       (ram_wr),
        .ram_din      (ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte RAM: combinational read of the presented address, write at the clock edge.
    assign ram_din = ram[ram_addr];
    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr] <= ram_dout;
        if (bd_we)  ram[bd_addr]  <= bd_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int access_len(input bit is_if, input logic [1:0] size);
        if (is_if) return 4;
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Little-endian read of n bytes from the shadow memory, wrapping at RAM size.
    function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = shadow[RAM_AW'(addr + 32'(i))];
        return v;
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [7:0] data);
        bd_we   = 1'b1;
        bd_addr = RAM_AW'(addr);
        bd_data = data;
        shadow[RAM_AW'(addr)] = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // One complete access from an idle controller, checked cycle by cycle against the model.
    task automatic run_access(input bit is_if, input bit we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        int          done_at;
        int          wr_cnt;
        logic [31:0] exp;
        n   = access_len(is_if, size);
        exp = model_read(addr, n);
        @(negedge clk);
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_size  = size;
            mem_addr  = addr;
            mem_wdata = wdata;
        end
        done_at = -1;
        wr_cnt  = 0;
        for (int c = 0; c < 12 && done_at < 0; c++) begin
            @(negedge clk);
            if (ram_wr) wr_cnt++;
            if (is_if ? if_done : mem_done) begin
                done_at = c;
            end else begin
                if (c < n) check("ram_addr", 32'(ram_addr), (addr + 32'(c)) & (RAM_SZ - 1));
                check("stall_busy", {31'd0, is_if ? if_stall_req : mem_stall_req}, 32'd1);
            end
        end
        check("latency", 32'(done_at), 32'(n));
        check("stall_done", {31'd0, is_if ? if_stall_req : mem_stall_req}, 32'd0);
        check("other_done", {31'd0, is_if ? mem_done : if_done}, 32'd0);
        check("wr_cycles", 32'(wr_cnt), (!is_if && we) ? 32'(n) : 32'd0);
        if (is_if) exp_if_data = exp;
        else if (!we) exp_mem_rdata = exp;
        check("if_data", if_data, exp_if_data);
        check("mem_rdata", mem_rdata, exp_mem_rdata);
        if_req  = 1'b0;
        mem_req = 1'b0;
        if (!is_if && we) begin
            for (int i = 0; i < n; i++) begin
                shadow[RAM_AW'(addr + 32'(i))] = wdata[8*i +: 8];
                check("store_byte", 32'(ram[RAM_AW'(addr + 32'(i))]), 32'(wdata[8*i +: 8]));
            end
        end
        @(negedge clk);
        check("done_pulse", {31'd0, is_if ? if_done : mem_done}, 32'd0);
    endtask

    initial begin
        int          mem_at;
        int          if_at;
        bit          stall_ok;
        bit          seen;
        logic [31:0] exp_i;
        logic [31:0] exp_m;
        logic [31:0] saved;

        checks = 0; failures = 0;
        exp_if_data = 32'd0; exp_mem_rdata = 32'd0;
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'd0; mem_wdata = 32'd0;
        bd_we = 1'b0; bd_addr = '0; bd_data = 8'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_if_data", if_data, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_ram_out", {14'd0, ram_addr, ram_wr}, 32'd0);
        check("rst_dout", 32'(ram_dout), 32'd0);
        check("rst_done", {30'd0, if_done, mem_done}, 32'd0);

        // Random background contents in the low window, then the fetch test word.
        for (int i = 0; i < 256; i++) preload(32'(i), 8'($urandom));
        preload(32'h100, 8'h13);
        preload(32'h101, 8'h05);
        preload(32'h102, 8'h10);
        preload(32'h103, 8'h00);
        rst = 1'b0;

        // Word fetch.
        run_access(1'b1, 1'b0, 2'b10, 32'h100, 32'd0);
        check("fetch_word", if_data, 32'h00100513);

        // Half store then byte load.
        run_access(1'b0, 1'b1, 2'b01, 32'h20, 32'h0000BEEF);
        check("half_lo", 32'(ram[17'h20]), 32'hEF);
        check("half_hi", 32'(ram[17'h21]), 32'hBE);
        run_access(1'b0, 1'b0, 2'b00, 32'h21, 32'd0);
        check("byte_load", mem_rdata, 32'h000000BE);

        // Simultaneous requests: MEM first, IF two edges after mem_done.
        exp_m = model_read(32'h40, 4);
        exp_i = model_read(32'h100, 4);
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h100;
        mem_at = -1; if_at = -1; stall_ok = 1'b1;
        for (int c = 0; c < 20 && if_at < 0; c++) begin
            @(negedge clk);
            if (mem_done && mem_at < 0) begin
                mem_at  = c;
                mem_req = 1'b0;
            end
            if (if_done) if_at = c;
            else if (!if_stall_req) stall_ok = 1'b0;
        end
        if_req = 1'b0;
        check("arb_mem_lat", 32'(mem_at), 32'd4);
        check("arb_if_lat", 32'(if_at), 32'd10);
        check("arb_if_stall", {31'd0, stall_ok}, 32'd1);
        check("arb_mem_data", mem_rdata, exp_m);
        check("arb_if_data", if_data, exp_i);
        exp_mem_rdata = exp_m;
        exp_if_data   = exp_i;
        @(negedge clk);

        // Flush sampled at E2 of a fetch: no done, data held.
        saved = if_data;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h30;
        @(negedge clk);
        @(negedge clk);
        if_flush = 1'b1;
        @(negedge clk);
        if_flush = 1'b0; if_req = 1'b0;
        seen = if_done;
        repeat (6) begin
            @(negedge clk);
            if (if_done) seen = 1'b1;
        end
        check("flush_no_done", {31'd0, seen}, 32'd0);
        check("flush_data", if_data, saved);
        check("flush_wr", {31'd0, ram_wr}, 32'd0);
        preload(32'h200, 8'h93);
        preload(32'h201, 8'h00);
        preload(32'h202, 8'hA0);
        preload(32'h203, 8'h02);
        run_access(1'b1, 1'b0, 2'b10, 32'h200, 32'd0);
        check("fetch_after_flush", if_data, 32'h02A00093);

        // Word store across the top of the RAM.
        run_access(1'b0, 1'b1, 2'b10, 32'h0001FFFF, 32'hA1B2C3D4);
        check("wrap_b0", 32'(ram[17'h1FFFF]), 32'hD4);
        check("wrap_b1", 32'(ram[17'h00000]), 32'hC3);
        check("wrap_b2", 32'(ram[17'h00001]), 32'hB2);
        check("wrap_b3", 32'(ram[17'h00002]), 32'hA1);
        run_access(1'b0, 1'b0, 2'b11, 32'h0001FFFF, 32'd0);

        // Randomized accesses against the shadow model.
        for (int t = 0; t < 40; t++) begin
            bit          r_if;
            bit          r_we;
            logic [1:0]  r_sz;
            logic [31:0] r_ad;
            r_if = ($urandom_range(0, 3) == 0);
            r_we = !r_if && ($urandom_range(0, 1) == 1);
            r_sz = 2'($urandom_range(0, 3));
            r_ad = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
            run_access(r_if, r_we, r_sz, r_ad, 32'($urandom));
        end

        // Reset in the middle of a load.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b10; mem_addr = 32'h44;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_data", if_data | mem_rdata, 32'd0);
        check("mid_rst_ram", {14'd0, ram_addr, ram_wr}, 32'd0);
        check("mid_rst_dout", 32'(ram_dout), 32'd0);
        check("mid_rst_done", {30'd0, if_done, mem_done}, 32'd0);
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_done || if_done) seen = 1'b1;
        end
        check("mid_rst_no_done", {31'd0, seen}, 32'd0);
        exp_if_data = 32'd0; exp_mem_rdata = 32'd0;
        run_access(1'b0, 1'b0, 2'b01, 32'h21, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
